// File: rtl/instr_seq_ctrl.sv
// Multicycle fetch/decode/execute/memory/writeback control FSM for the 16-bit, 3-bit-opcode core.
// Optional: define SEQ_PERF_CNT_EN to add saturating retired_cnt / stall_cnt performance counters.
module instr_seq_ctrl #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [2:0]        opcode,
    input  logic              eq_flag,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              imem_req,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic [1:0]        alu_op,
    output logic              flag_we,
    output logic              mem_req,
    output logic              mem_we,
`ifdef SEQ_PERF_CNT_EN
    output logic [PERF_W-1:0] retired_cnt,
    output logic [PERF_W-1:0] stall_cnt,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_SET   = 3'b000,
        OP_LDPX  = 3'b001,
        OP_MODEX = 3'b010,
        OP_STPX  = 3'b011,
        OP_CMPEQ = 3'b100,
        OP_JEQ   = 3'b101,
        OP_J     = 3'b110,
        OP_ADD   = 3'b111
    } op_t;

    localparam logic [1:0] WB_ALU = 2'b00, WB_IMM = 2'b01, WB_MEM = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b00, ALU_MOD = 2'b01, ALU_CMP = 2'b10;

    if (PERF_W < 1) begin : g_perf_w_check
        $error("PERF_W must be at least 1");
    end

    state_t state, next_state, instr_end;
    op_t    op_q;

    // run is only consulted here, at the boundary between instructions.
    assign instr_end = run ? FETCH : IDLE;

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments and a synchronous reset sampled on the clock edge.
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_SET;
        end else begin
            state <= next_state;
            if (state == DECODE)
                op_q <= op_t'(opcode);
        end
    end

    always_comb begin
        // NOTE: every output and next_state get a default first so no path through the case infers a latch.
        next_state = state;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        reg_we     = 1'b0;
        wb_sel     = WB_ALU;
        alu_op     = ALU_ADD;
        flag_we    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: if (run) next_state = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: next_state = EXEC;
            EXEC: begin
                next_state = instr_end;
                unique case (op_q)
                    OP_SET:   begin reg_we = 1'b1; wb_sel = WB_IMM; pc_inc = 1'b1; end
                    OP_ADD:   begin reg_we = 1'b1; alu_op = ALU_ADD; pc_inc = 1'b1; end
                    OP_MODEX: begin reg_we = 1'b1; alu_op = ALU_MOD; pc_inc = 1'b1; end
                    OP_CMPEQ: begin flag_we = 1'b1; alu_op = ALU_CMP; pc_inc = 1'b1; end
                    OP_J:     pc_load = 1'b1;
                    OP_JEQ:   begin pc_load = eq_flag; pc_inc = !eq_flag; end
                    OP_LDPX, OP_STPX: next_state = MEM;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_STPX);
                if (dmem_ready) begin
                    if (op_q == OP_STPX) begin
                        pc_inc     = 1'b1;
                        next_state = instr_end;
                    end else begin
                        next_state = WB;
                    end
                end
            end
            WB: begin
                reg_we     = 1'b1;
                wb_sel     = WB_MEM;
                pc_inc     = 1'b1;
                next_state = instr_end;
            end
            default: next_state = IDLE;
        endcase

        // A reset cycle must never commit architectural state, even if a ready arrives with it.
        if (rst) begin
            ir_load = 1'b0;
            pc_inc  = 1'b0;
            pc_load = 1'b0;
            reg_we  = 1'b0;
            flag_we = 1'b0;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if ((pc_inc || pc_load) && retired_cnt != '1)
                retired_cnt <= retired_cnt + 1'b1;
            if (((state == FETCH && !imem_ready) || (state == MEM && !dmem_ready)) && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: directed scenarios with literal expectations, then
// randomized stimulus compared every cycle against a per-instruction behavioural model.
module tb_instr_seq_ctrl;

    localparam logic [2:0] SET = 3'b000, LDPX = 3'b001, MODEX = 3'b010, STPX = 3'b011;
    localparam logic [2:0] CMPEQ = 3'b100, JEQ = 3'b101, J = 3'b110, ADD = 3'b111;
    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3, PH_MEM = 4, PH_WB = 5;

    logic clk = 1'b0;
    logic rst = 1'b1, run = 1'b0, eq_flag = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic [2:0] opcode = SET;
    logic imem_req, ir_load, pc_inc, pc_load, reg_we, flag_we, mem_req, mem_we, busy;
    logic [1:0] wb_sel, alu_op;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    instr_seq_ctrl #(.PERF_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .eq_flag(eq_flag),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we),
        .wb_sel(wb_sel), .alu_op(alu_op), .flag_we(flag_we), .mem_req(mem_req),
        .mem_we(mem_we),
`ifdef SEQ_PERF_CNT_EN
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Bit order: imem_req ir_load pc_inc pc_load reg_we wb_sel[2] alu_op[2] flag_we mem_req mem_we busy
    wire [12:0] dut_out = {imem_req, ir_load, pc_inc, pc_load, reg_we, wb_sel, alu_op,
                           flag_we, mem_req, mem_we, busy};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what each phase of an instruction must drive, stated per opcode class.
    function automatic logic [12:0] model_out(input int ph, input logic [2:0] op, input logic r,
                                              input logic ir, input logic dr, input logic eq);
        logic writes_reg, is_mem, taken, retire, ld_ir, inc, ld_pc, we, fwe, mreq, mwe;
        logic [1:0] wb, alu;
        writes_reg = (op == SET) || (op == ADD) || (op == MODEX);
        is_mem     = (op == LDPX) || (op == STPX);
        taken      = (op == J) || (op == JEQ && eq);
        ld_ir = 1'b0; inc = 1'b0; ld_pc = 1'b0; we = 1'b0; fwe = 1'b0; mreq = 1'b0; mwe = 1'b0;
        wb = 2'b00; alu = 2'b00;
        if (ph == PH_FETCH) ld_ir = ir;
        if (ph == PH_EXEC && !is_mem) begin
            retire = 1'b1;
            ld_pc  = retire && taken;
            inc    = retire && !taken;
            we     = writes_reg;
            wb     = (op == SET) ? 2'b01 : 2'b00;
            alu    = (op == MODEX) ? 2'b01 : (op == CMPEQ) ? 2'b10 : 2'b00;
            fwe    = (op == CMPEQ);
        end
        if (ph == PH_MEM) begin
            mreq = 1'b1;
            mwe  = (op == STPX);
            inc  = dr && (op == STPX);
        end
        if (ph == PH_WB) begin
            we = 1'b1; wb = 2'b10; inc = 1'b1;
        end
        if (r) begin
            ld_ir = 1'b0; inc = 1'b0; ld_pc = 1'b0; we = 1'b0; fwe = 1'b0;
        end
        return {ph == PH_FETCH, ld_ir, inc, ld_pc, we, wb, alu, fwe, mreq, mwe, ph != PH_IDLE};
    endfunction

    int          m_ph = PH_IDLE;
    logic [2:0]  m_op = SET;
    logic        m_valid = 1'b0;
    logic [31:0] m_ret = '0, m_stall = '0;

    always @(posedge clk) begin
        logic [12:0] cur;
        cur = model_out(m_ph, m_op, rst, imem_ready, dmem_ready, eq_flag);
        if (rst) begin
            m_ph = PH_IDLE; m_op = SET; m_valid = 1'b1; m_ret = '0; m_stall = '0;
        end else begin
            if ((cur[10] || cur[9]) && m_ret != '1) m_ret++;
            if (((m_ph == PH_FETCH && !imem_ready) || (m_ph == PH_MEM && !dmem_ready)) && m_stall != '1)
                m_stall++;
            case (m_ph)
                PH_IDLE:   if (run) m_ph = PH_FETCH;
                PH_FETCH:  if (imem_ready) m_ph = PH_DECODE;
                PH_DECODE: begin m_op = opcode; m_ph = PH_EXEC; end
                PH_EXEC:   m_ph = (m_op == LDPX || m_op == STPX) ? PH_MEM : (run ? PH_FETCH : PH_IDLE);
                PH_MEM:    if (dmem_ready) m_ph = (m_op == LDPX) ? PH_WB : (run ? PH_FETCH : PH_IDLE);
                default:   m_ph = run ? PH_FETCH : PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cycle_outputs", 64'(dut_out),
                  64'(model_out(m_ph, m_op, rst, imem_ready, dmem_ready, eq_flag)));
`ifdef SEQ_PERF_CNT_EN
            check("retired_cnt", 64'(retired_cnt), 64'(m_ret));
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        end
    end

    task automatic adv(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    initial begin
        int cycles, mem_seen;
        logic done;

        check("pin_model_set_exec", 64'(model_out(PH_EXEC, SET, 1'b0, 1'b1, 1'b1, 1'b0)), 64'(13'b0010101000001));
        check("pin_model_stpx_mem", 64'(model_out(PH_MEM, STPX, 1'b0, 1'b1, 1'b1, 1'b0)), 64'(13'b0010000000111));
        check("pin_model_jeq_taken", 64'(model_out(PH_EXEC, JEQ, 1'b0, 1'b1, 1'b1, 1'b1)), 64'(13'b0001000000001));

        // Reset held two cycles, then a stream of SETs with ready tied high.
        adv(); adv();
        smp(); check("reset_outputs_zero", 64'(dut_out), 64'd0);
        adv();
        rst = 1'b0; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = SET;
        smp(); check("idle_after_reset", 64'(dut_out), 64'd0);
        adv();
        for (int i = 0; i < 3; i++) begin
            smp(); check("set_fetch_strobes", 64'({imem_req, ir_load, busy}), 64'(3'b111));
            adv();
            smp(); check("set_decode_quiet", 64'({busy, pc_inc, reg_we, imem_req}), 64'(4'b1000));
            adv();
            smp(); check("set_exec", 64'({pc_inc, pc_load, reg_we, wb_sel}), 64'(5'b10101));
            adv();
        end

        // LDPX with three cycles of memory stall.
        opcode = LDPX; cycles = 0; mem_seen = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            dmem_ready = (mem_seen >= 3);
            smp();
            cycles++;
            if (mem_req) begin
                mem_seen++;
                check("ldpx_mem_we_low", 64'(mem_we), 64'd0);
            end
            if (pc_inc) begin
                check("ldpx_wb", 64'({reg_we, wb_sel, pc_load}), 64'(4'b1100));
                done = 1'b1;
            end
            adv();
        end
        check("ldpx_completed", 64'(done), 64'd1);
        check("ldpx_total_cycles", 64'(cycles), 64'd8);
        check("ldpx_mem_req_cycles", 64'(mem_seen), 64'd4);
        dmem_ready = 1'b1;

        // JEQ taken, then not taken.
        opcode = JEQ; eq_flag = 1'b1;
        smp(); adv(); smp(); adv(); smp();
        check("jeq_taken", 64'({pc_load, pc_inc}), 64'(2'b10));
        adv();
        eq_flag = 1'b0;
        smp(); adv(); smp(); adv(); smp();
        check("jeq_not_taken", 64'({pc_load, pc_inc}), 64'(2'b01));
        adv();

        // STPX with run dropped during DECODE completes, then goes idle.
        opcode = STPX;
        adv();
        run = 1'b0;
        smp(); adv();
        smp(); check("stpx_exec_no_pc", 64'({pc_inc, pc_load, mem_req}), 64'd0);
        adv();
        smp(); check("stpx_mem", 64'({mem_req, mem_we, pc_inc}), 64'(3'b111));
        adv();
        smp(); check("stpx_then_idle", 64'(dut_out), 64'd0);
        adv();
        smp(); check("stays_idle", 64'(busy), 64'd0);

        // Reset arriving while LDPX waits in MEM.
        run = 1'b1; opcode = LDPX; dmem_ready = 1'b0;
        adv(); adv(); adv(); adv();
        rst = 1'b1;
        smp(); check("rst_cycle_mem", 64'({mem_req, reg_we, pc_inc, busy}), 64'(4'b1001));
        adv();
        rst = 1'b0; run = 1'b0;
        smp(); check("after_rst_in_mem", 64'(dut_out), 64'd0);
        adv();

`ifdef SEQ_PERF_CNT_EN
        // Ten SETs with two imem stall cycles on the first fetch.
        rst = 1'b1; adv();
        rst = 1'b0; opcode = SET; dmem_ready = 1'b1;
        for (int c = 0; c < 33; c++) begin
            imem_ready = !(c == 1 || c == 2);
            run = (c < 30);
            adv();
        end
        smp();
        check("perf_retired_10", 64'(retired_cnt), 64'd10);
        check("perf_stall_2", 64'(stall_cnt), 64'd2);
        adv();
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            run        = ($urandom_range(0, 7) != 0);
            opcode     = 3'($urandom_range(0, 7));
            eq_flag    = 1'($urandom_range(0, 1));
            imem_ready = ($urandom_range(0, 3) != 0);
            dmem_ready = ($urandom_range(0, 3) != 0);
            adv();
        end
        smp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
